// File: rtl/addsub_arbiter.sv
// rtl/addsub_arbiter.sv - round-robin command arbiter in front of AddSub (option macro: ADDSUB_ARB_PRIO0_EN)
module addsub_arbiter #(
    parameter int  NREQ       = 4,
    parameter int  MAGW       = 10,
    parameter int  SETTLE_CYC = 2,
    localparam int IDW        = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_dir,
    input  logic [NREQ*MAGW-1:0] req_mag,
    output logic [NREQ-1:0]      gnt,
    output logic                 as_en,
    output logic                 as_dir,
    output logic [MAGW-1:0]      as_mag,
    output logic                 busy,
    output logic [IDW-1:0]       last_id
);

    localparam int CW = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state;
    logic [IDW-1:0]  r_rr_ptr;
    logic [IDW-1:0]  w_rr_ptr;
    logic [IDW-1:0]  w_rr_adv;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] w_gnt;
    logic            r_as_en;
    logic            w_as_en;
    logic            r_as_dir;
    logic            w_as_dir;
    logic [MAGW-1:0] r_as_mag;
    logic [MAGW-1:0] w_as_mag;
    logic            r_busy;
    logic            w_busy;
    logic [IDW-1:0]  r_last_id;
    logic [IDW-1:0]  w_last_id;
    logic            w_found;
    logic [IDW-1:0]  w_sel;
    logic [MAGW-1:0] w_req_mag;

    assign gnt     = r_gnt;
    assign as_en   = r_as_en;
    assign as_dir  = r_as_dir;
    assign as_mag  = r_as_mag;
    assign busy    = r_busy;
    assign last_id = r_last_id;

    assign w_req_mag = req_mag[int'(w_sel) * MAGW +: MAGW];

    // Choose the first pending requester starting at the round-robin pointer
    always_comb begin : p_select
        int             v_base;
        int             v_idx;
        logic [IDW-1:0] v_bit;
        w_found = 1'b0;
        w_sel   = '0;
        v_base  = 0;
        v_idx   = 0;
        v_bit   = '0;
`ifdef ADDSUB_ARB_PRIO0_EN
        // Requester 0 always wins; the rotating scan covers 1..NREQ-1 only
        v_base = (r_rr_ptr == '0) ? 1 : int'(r_rr_ptr);
        if (req[0]) begin
            w_found = 1'b1;
        end else begin
            for (int k = 0; k < NREQ - 1; k++) begin
                v_idx = 1 + ((v_base - 1 + k) % (NREQ - 1));
                v_bit = IDW'(v_idx);
                if (!w_found && req[v_bit]) begin
                    w_found = 1'b1;
                    w_sel   = v_bit;
                end
            end
        end
`else
        v_base = int'(r_rr_ptr);
        for (int k = 0; k < NREQ; k++) begin
            v_idx = (v_base + k) % NREQ;
            v_bit = IDW'(v_idx);
            if (!w_found && req[v_bit]) begin
                w_found = 1'b1;
                w_sel   = v_bit;
            end
        end
`endif
    end

    // Pointer value one past the requester just granted
    always_comb begin
        if (r_last_id == IDW'(NREQ - 1)) begin
`ifdef ADDSUB_ARB_PRIO0_EN
            w_rr_adv = IDW'(1);
`else
            w_rr_adv = '0;
`endif
        end else begin
            w_rr_adv = r_last_id + IDW'(1);
        end
    end

    // Next state and next registered outputs
    always_comb begin
        w_state   = r_state;
        w_gnt     = '0;
        w_as_en   = 1'b0;
        w_as_dir  = r_as_dir;
        w_as_mag  = r_as_mag;
        w_last_id = r_last_id;
        w_rr_ptr  = r_rr_ptr;
        w_cnt     = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state      = S_ISSUE;
                    w_gnt[w_sel] = 1'b1;
                    w_as_en      = |w_req_mag;
                    w_as_dir     = req_dir[w_sel];
                    w_as_mag     = w_req_mag;
                    w_last_id    = w_sel;
                end
            end
            S_ISSUE: begin
                w_rr_ptr = w_rr_adv;
                // A zero-magnitude command never reached AddSub, so nothing needs to settle
                if (r_as_mag != '0) begin
                    w_state = S_SETTLE;
                    w_cnt   = CW'(SETTLE_CYC);
                end else begin
                    w_state = S_IDLE;
                end
            end
            S_SETTLE: begin
                w_cnt = r_cnt - CW'(1);
                if (r_cnt <= CW'(1)) begin
                    w_state = S_IDLE;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
        w_busy = (w_state != S_IDLE);
    end

    // State, pointer, counter and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rr_ptr  <= '0;
            r_cnt     <= '0;
            r_gnt     <= '0;
            r_as_en   <= 1'b0;
            r_as_dir  <= 1'b0;
            r_as_mag  <= '0;
            r_busy    <= 1'b0;
            r_last_id <= '0;
        end else begin
            r_state   <= w_state;
            r_rr_ptr  <= w_rr_ptr;
            r_cnt     <= w_cnt;
            r_gnt     <= w_gnt;
            r_as_en   <= w_as_en;
            r_as_dir  <= w_as_dir;
            r_as_mag  <= w_as_mag;
            r_busy    <= w_busy;
            r_last_id <= w_last_id;
        end
    end

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb/tb_addsub_arbiter.sv - scoreboard bench for addsub_arbiter with a timing-rule reference model
module tb_addsub_arbiter;

    localparam int NREQ       = 4;
    localparam int MAGW       = 10;
    localparam int SETTLE_CYC = 2;
    localparam int IDW        = $clog2(NREQ);

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      req_dir;
    logic [NREQ*MAGW-1:0] req_mag;
    logic [NREQ-1:0]      gnt;
    logic                 as_en;
    logic                 as_dir;
    logic [MAGW-1:0]      as_mag;
    logic                 busy;
    logic [IDW-1:0]       last_id;

    addsub_arbiter #(
        .NREQ      (NREQ),
        .MAGW      (MAGW),
        .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .req_dir(req_dir),
        .req_mag(req_mag),
        .gnt    (gnt),
        .as_en  (as_en),
        .as_dir (as_dir),
        .as_mag (as_mag),
        .busy   (busy),
        .last_id(last_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int              cyc;
        int              id;
        logic            en;
        logic [MAGW-1:0] mag;
        logic            dir;
    } exp_t;

    exp_t            sb[$];
    int              checks = 0;
    int              errors = 0;
    int              cyc = 0;
    bit              started = 0;
    bit              done = 0;
    int              rr = 0;
    int              next_arb = 0;
    int              busy_until = -1;
    logic [MAGW-1:0] hold_mag = '0;
    logic            hold_dir = 1'b0;
    logic [IDW-1:0]  hold_id = '0;
    logic [NREQ-1:0] keep_mask = '0;
    logic [NREQ-1:0] last_seen = '0;

    // Reference arbitration: first pending requester in rotating order from ptr
    function automatic int pick(input logic [NREQ-1:0] r, input int ptr);
        int i;
`ifdef ADDSUB_ARB_PRIO0_EN
        int b;
        if (r[0]) return 0;
        b = (ptr == 0) ? 1 : ptr;
        for (int k = 0; k < NREQ - 1; k++) begin
            i = 1 + ((b - 1 + k) % (NREQ - 1));
            if (r[i]) return i;
        end
`else
        for (int k = 0; k < NREQ; k++) begin
            i = (ptr + k) % NREQ;
            if (r[i]) return i;
        end
`endif
        return -1;
    endfunction

    function automatic int ptr_after(input int id);
        int p;
        p = (id + 1) % NREQ;
`ifdef ADDSUB_ARB_PRIO0_EN
        if (p == 0) p = 1;
`endif
        return p;
    endfunction

    // Reference model: one decision per free arbitration slot, spaced by the settle rules
    always @(posedge clk) begin : model
        int   id;
        exp_t e;
        cyc = cyc + 1;
        if (rst === 1'b1) begin
            started    = 1;
            rr         = 0;
            next_arb   = cyc + 1;
            busy_until = cyc - 1;
            hold_mag   = '0;
            hold_dir   = 1'b0;
            hold_id    = '0;
            sb.delete();
        end else if (started && cyc >= next_arb && req != '0) begin
            id = pick(req, rr);
            if (id >= 0) begin
                e.cyc = cyc;
                e.id  = id;
                e.mag = req_mag[id*MAGW +: MAGW];
                e.dir = req_dir[id];
                e.en  = (e.mag != '0);
                sb.push_back(e);
                busy_until = cyc + (e.en ? SETTLE_CYC : 0);
                next_arb   = busy_until + 2;
                hold_mag   = e.mag;
                hold_dir   = e.dir;
                hold_id    = IDW'(id);
                rr         = ptr_after(id);
            end
        end
    end

    // Monitor: per-cycle busy/hold checks, pops the scoreboard whenever a grant appears
    always @(negedge clk) begin : monitor
        exp_t            e;
        logic [NREQ-1:0] eg;
        logic            eb;
        if (started && !done) begin
            eb = (cyc <= busy_until);
            checks++;
            if (busy !== eb) begin
                errors++;
                $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, eb);
            end
            checks++;
            if (as_mag !== hold_mag || as_dir !== hold_dir || last_id !== hold_id) begin
                errors++;
                $display("FAIL hold cyc=%0d got mag=%0d dir=%b id=%0d want mag=%0d dir=%b id=%0d",
                         cyc, as_mag, as_dir, last_id, hold_mag, hold_dir, hold_id);
            end
            if (gnt !== '0 || as_en !== 1'b0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_grant cyc=%0d got gnt=%b en=%b want none", cyc, gnt, as_en);
                end else begin
                    e  = sb.pop_front();
                    eg = '0;
                    eg[e.id] = 1'b1;
                    if (e.cyc != cyc || gnt !== eg || as_en !== e.en || as_mag !== e.mag || as_dir !== e.dir) begin
                        errors++;
                        $display("FAIL grant cyc=%0d got gnt=%b en=%b mag=%0d dir=%b want cyc=%0d gnt=%b en=%b mag=%0d dir=%b",
                                 cyc, gnt, as_en, as_mag, as_dir, e.cyc, eg, e.en, e.mag, e.dir);
                    end
                end
            end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_grant cyc=%0d got gnt=%b want id=%0d", cyc, gnt, sb[0].id);
                void'(sb.pop_front());
            end
        end
    end

    task automatic set_cmd(input int i, input int mag, input logic dir);
        req_mag[i*MAGW +: MAGW] = MAGW'(mag);
        req_dir[i] = dir;
        req[i]     = 1'b1;
    endtask

    // One clock: observe grants, then apply the requester rule after the edge
    task automatic step();
        logic [NREQ-1:0] seen;
        @(negedge clk);
        seen = gnt;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (seen[i] === 1'b1) begin
                if (keep_mask[i]) set_cmd(i, int'($urandom_range(1, 1000)), $urandom_range(0, 1) == 1);
                else req[i] = 1'b0;
            end
        end
        last_seen = seen;
    endtask

    task automatic new_cmd(input int i);
        int m;
        m = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, (1 << MAGW) - 1));
        set_cmd(i, m, $urandom_range(0, 1) == 1);
    endtask

    // Random requester behaviour, including withdrawals, late data changes and resets
    task automatic step_rand();
        logic [NREQ-1:0] seen;
        @(negedge clk);
        seen = gnt;
        @(posedge clk);
        #1;
        if (rst) rst = 1'b0;
        else if ($urandom_range(0, 249) == 0) rst = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            if (seen[i] === 1'b1) begin
                if ($urandom_range(0, 2) == 0) new_cmd(i);
                else req[i] = 1'b0;
            end else if (!req[i]) begin
                if ($urandom_range(0, 3) == 0) new_cmd(i);
            end else if ($urandom_range(0, 39) == 0) begin
                req[i] = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
                req_mag[i*MAGW +: MAGW] = MAGW'($urandom_range(0, (1 << MAGW) - 1));
                req_dir[i] = $urandom_range(0, 1) == 1;
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        req     = '0;
        req_dir = '0;
        req_mag = '0;
        // Reset held with all four requesting, then contention 5/3/7/1
        set_cmd(0, 5, 1'b0);
        set_cmd(1, 3, 1'b1);
        set_cmd(2, 7, 1'b0);
        set_cmd(3, 1, 1'b1);
        repeat (2) step();
        rst = 1'b0;
        repeat (20) step();
        // Single request
        set_cmd(2, 5, 1'b0);
        repeat (8) step();
        // Fairness: 0 and 3 both re-present after every grant
        keep_mask = 4'b1001;
        set_cmd(0, 11, 1'b0);
        set_cmd(3, 22, 1'b1);
        repeat (24) step();
        keep_mask = '0;
        repeat (12) step();
        // Zero magnitude followed by another requester
        set_cmd(1, 0, 1'b1);
        step();
        set_cmd(2, 9, 1'b0);
        repeat (10) step();
        // Reset in the second settle cycle with requester 3 pending
        set_cmd(1, 4, 1'b0);
        for (int n = 0; n < 10; n++) begin
            step();
            if (last_seen != '0) break;
        end
        set_cmd(3, 6, 1'b1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (10) step();
`ifdef ADDSUB_ARB_PRIO0_EN
        req = '0;
        repeat (6) step();
        set_cmd(1, 12, 1'b0);
        set_cmd(3, 13, 1'b1);
        repeat (2) step();
        set_cmd(0, 14, 1'b0);
        repeat (20) step();
`endif
        // Randomized traffic
        repeat (3000) step_rand();
        rst = 1'b0;
        req = '0;
        repeat (12) step();
        done = 1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got pending=%0d want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
